// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundle of every non-clock signal around the sprite SRAM
// arbiter.
//   Port 0 (display, read only): req0, addr0 -> ack0, rvalid0, rdata0
//   Port 1 (game logic, r/w)   : req1, we1, addr1, wdata1 -> ack1, rvalid1, rdata1
//   Clear engine               : clear_start -> clear_busy, clear_done
//   SRAM pins                  : sram_en, sram_we, sram_addr, sram_wdata <- sram_rdata
// The slave modport is the arbiter's view. The master modport is the view of
// the surroundings, meaning the requesters and the SRAM.
interface sram_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  req0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic                  ack0;
    logic                  rvalid0;
    logic [DATA_WIDTH-1:0] rdata0;

    logic                  req1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack1;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata1;

    logic                  clear_start;
    logic                  clear_busy;
    logic                  clear_done;

    logic                  sram_en;
    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;

    modport slave (
        input  req0, addr0, req1, we1, addr1, wdata1, clear_start, sram_rdata,
        output ack0, rvalid0, rdata0, ack1, rvalid1, rdata1,
               clear_busy, clear_done, sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output req0, addr0, req1, we1, addr1, wdata1, clear_start, sram_rdata,
        input  ack0, rvalid0, rdata0, ack1, rvalid1, rdata1,
               clear_busy, clear_done, sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares a single-port sprite SRAM that has a 1-cycle registered
// read. Port 0 is the display read path and has priority. Port 1 is the game
// logic read/write path, and it wins contention after STARVE_LIMIT
// consecutive denied cycles. A fill engine writes CLEAR_VAL into cells
// 0..RAM_SIZE-1.
// Ports: clk, rst (async, active high), and bus (sram_arbiter_if.slave).
// Grants and SRAM pins are combinational. Read returns, clear_busy and
// clear_done are registered.
module sram_arbiter #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    RAM_SIZE     = 65536,
    parameter int                    STARVE_LIMIT = 4,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL    = '0
) (
    input  logic             clk,
    input  logic             rst,
    sram_arbiter_if.slave    bus
);
    localparam int                    STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(RAM_SIZE - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [ADDR_WIDTH-1:0] clr_addr_r;
    logic [STARVE_W-1:0]   starve_cnt_r;
    logic                  clear_done_r;
    logic                  rd0_p1_r;
    logic                  rd1_p1_r;
    logic                  rvalid0_r;
    logic                  rvalid1_r;
    logic [DATA_WIDTH-1:0] rdata0_r;
    logic [DATA_WIDTH-1:0] rdata1_r;

    logic                  grant0_s;
    logic                  grant1_s;
    logic                  in_clear_s;
    logic                  clr_last_s;
    logic                  sram_en_s;
    logic                  sram_we_s;
    logic [ADDR_WIDTH-1:0] sram_addr_s;
    logic [DATA_WIDTH-1:0] sram_wdata_s;

    // Decoded views of the current state. Reset gates them so the SRAM pins fall at once.
    assign in_clear_s = (state_r == ST_CLEAR) && !rst;
    assign clr_last_s = (clr_addr_r == LAST_ADDR);

    // Arbitration. Port 0 wins ties unless port 1 has been denied STARVE_LIMIT times in a row.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst || (state_r == ST_CLEAR)) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (bus.req0 && bus.req1) begin
            if (starve_cnt_r == STARVE_MAX) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b1;
            end
        end else begin
            grant0_s = bus.req0;
            grant1_s = bus.req1;
        end
    end

    // Next-state logic. clear_start is only honoured from IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.clear_start) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // SRAM pin mux. The clear writes, then port 1, then port 0 (port 0 only ever reads).
    always_comb begin
        sram_en_s    = 1'b0;
        sram_we_s    = 1'b0;
        sram_addr_s  = '0;
        sram_wdata_s = '0;
        if (in_clear_s) begin
            sram_en_s    = 1'b1;
            sram_we_s    = 1'b1;
            sram_addr_s  = clr_addr_r;
            sram_wdata_s = CLEAR_VAL;
        end else if (grant1_s) begin
            sram_en_s    = 1'b1;
            sram_we_s    = bus.we1;
            sram_addr_s  = bus.addr1;
            sram_wdata_s = bus.wdata1;
        end else if (grant0_s) begin
            sram_en_s    = 1'b1;
            sram_addr_s  = bus.addr0;
        end else begin
            sram_en_s    = 1'b0;
        end
    end

    // State register, clear address walker and the completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            clr_addr_r   <= '0;
            clear_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            clear_done_r <= (state_r == ST_CLEAR) && clr_last_s;
            if ((state_r == ST_CLEAR) && !clr_last_s) begin
                clr_addr_r <= clr_addr_r + ADDR_WIDTH'(1);
            end else begin
                clr_addr_r <= '0;
            end
        end
    end

    // Saturating count of consecutive cycles in which port 1 asked and was refused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= '0;
        end else if (bus.req1 && !grant1_s) begin
            if (starve_cnt_r != STARVE_MAX) begin
                starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= '0;
        end
    end

    // Read tag pipeline. A tag issued in N sees the SRAM data in N+1 and presents it in N+2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd0_p1_r  <= 1'b0;
            rd1_p1_r  <= 1'b0;
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            rdata0_r  <= '0;
            rdata1_r  <= '0;
        end else begin
            rd0_p1_r  <= grant0_s;
            rd1_p1_r  <= grant1_s && !bus.we1;
            rvalid0_r <= rd0_p1_r;
            rvalid1_r <= rd1_p1_r;
            if (rd0_p1_r) begin
                rdata0_r <= bus.sram_rdata;
            end else begin
                rdata0_r <= rdata0_r;
            end
            if (rd1_p1_r) begin
                rdata1_r <= bus.sram_rdata;
            end else begin
                rdata1_r <= rdata1_r;
            end
        end
    end

    assign bus.ack0       = grant0_s;
    assign bus.ack1       = grant1_s;
    assign bus.rvalid0    = rvalid0_r;
    assign bus.rvalid1    = rvalid1_r;
    assign bus.rdata0     = rdata0_r;
    assign bus.rdata1     = rdata1_r;
    assign bus.clear_busy = (state_r == ST_CLEAR);
    assign bus.clear_done = clear_done_r;
    assign bus.sram_en    = sram_en_s;
    assign bus.sram_we    = sram_we_s;
    assign bus.sram_addr  = sram_addr_s;
    assign bus.sram_wdata = sram_wdata_s;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: self-checking bench for sram_arbiter. It holds a
// behavioural SRAM with a 1-cycle registered read, plus a reference memory.
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled
// on the falling edge.
module tb_sram_arbiter;
    localparam int         DW = 8;
    localparam int         AW = 16;
    localparam int         RS = 16;
    localparam int         SL = 4;
    localparam logic [7:0] CV = 8'hFF;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    always #5 clk = ~clk;

    sram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sram_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_SIZE(RS),
        .STARVE_LIMIT(SL), .CLEAR_VAL(CV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural single-port SRAM with a registered read.
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
            else             bus.sram_rdata     <= mem[bus.sram_addr];
        end
    end

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_pt();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we1 = 1'b0;
        bus.clear_start = 1'b0;
    endtask

    task automatic settle();
        idle_inputs();
        for (int i = 0; i < 4; i++) drive_pt();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.we1 = 1'b1; bus.clear_start = 1'b0;
        bus.addr0 = 16'h0001; bus.addr1 = 16'h0002; bus.wdata1 = 8'h11;
        for (int i = 0; i < 3; i++) begin
            sample_pt();
            n_cmp++;
            if ({bus.ack0, bus.ack1, bus.sram_en, bus.sram_we} !== 4'b0000) begin
                n_bad++; $display("FAIL reset_comb: got %b expected 0000", {bus.ack0, bus.ack1, bus.sram_en, bus.sram_we});
            end
            n_cmp++;
            if ({bus.rvalid0, bus.rvalid1, bus.clear_busy, bus.clear_done} !== 4'b0000) begin
                n_bad++; $display("FAIL reset_flags: got %b expected 0000", {bus.rvalid0, bus.rvalid1, bus.clear_busy, bus.clear_done});
            end
            n_cmp++;
            if ({bus.rdata0, bus.rdata1} !== 16'h0000) begin
                n_bad++; $display("FAIL reset_rdata: got %h expected 0000", {bus.rdata0, bus.rdata1});
            end
        end
        drive_pt();
        idle_inputs();
        rst = 1'b0;
        settle();
    endtask

    task automatic test_port0_single();
        drive_pt();
        bus.req0 = 1'b1; bus.addr0 = 16'h0010;
        sample_pt();
        n_cmp++;
        if ({bus.ack0, bus.ack1, bus.sram_en, bus.sram_we, bus.sram_addr} !== {4'b1010, 16'h0010}) begin
            n_bad++; $display("FAIL p0_issue: got %h expected %h", {bus.ack0, bus.ack1, bus.sram_en, bus.sram_we, bus.sram_addr}, {4'b1010, 16'h0010});
        end
        drive_pt();
        bus.req0 = 1'b0;
        sample_pt();
        n_cmp++;
        if (bus.rvalid0 !== 1'b0) begin
            n_bad++; $display("FAIL p0_early: got %b expected 0", bus.rvalid0);
        end
        drive_pt();
        sample_pt();
        n_cmp++;
        if ({bus.rvalid0, bus.rdata0} !== {1'b1, 8'hA5}) begin
            n_bad++; $display("FAIL p0_return: got %h expected %h", {bus.rvalid0, bus.rdata0}, {1'b1, 8'hA5});
        end
        drive_pt();
        sample_pt();
        n_cmp++;
        if (bus.rvalid0 !== 1'b0) begin
            n_bad++; $display("FAIL p0_pulse: got %b expected 0", bus.rvalid0);
        end
        settle();
    endtask

    task automatic test_p1_write_read();
        drive_pt();
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h1234; bus.wdata1 = 8'h3C;
        sample_pt();
        n_cmp++;
        if ({bus.ack1, bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata} !== {3'b111, 16'h1234, 8'h3C}) begin
            n_bad++; $display("FAIL p1_write: got %h expected %h", {bus.ack1, bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata}, {3'b111, 16'h1234, 8'h3C});
        end
        ref_mem[16'h1234] = 8'h3C;
        drive_pt();
        bus.we1 = 1'b0;
        sample_pt();
        n_cmp++;
        if ({bus.ack1, bus.sram_we} !== 2'b10) begin
            n_bad++; $display("FAIL p1_read_issue: got %b expected 10", {bus.ack1, bus.sram_we});
        end
        drive_pt();
        bus.req1 = 1'b0;
        sample_pt();
        n_cmp++;
        if (bus.rvalid1 !== 1'b0) begin
            n_bad++; $display("FAIL p1_write_rvalid: got %b expected 0", bus.rvalid1);
        end
        drive_pt();
        sample_pt();
        n_cmp++;
        if ({bus.rvalid1, bus.rdata1} !== {1'b1, ref_mem[16'h1234]}) begin
            n_bad++; $display("FAIL p1_read_return: got %h expected %h", {bus.rvalid1, bus.rdata1}, {1'b1, ref_mem[16'h1234]});
        end
        settle();
    endtask

    task automatic test_starvation();
        int  denied = 0;
        int  n_ack1 = 0;
        bit  exp1;
        for (int c = 0; c < 20; c++) begin
            drive_pt();
            bus.req0 = 1'b1; bus.addr0 = 16'(c);
            bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'(c + 100);
            exp1   = (denied == SL);
            denied = exp1 ? 0 : ((denied < SL) ? denied + 1 : denied);
            sample_pt();
            n_cmp++;
            if ({bus.ack0, bus.ack1} !== {!exp1, exp1}) begin
                n_bad++; $display("FAIL starve_grant: cycle %0d got %b expected %b", c, {bus.ack0, bus.ack1}, {!exp1, exp1});
            end
            if (bus.ack1 === 1'b1) n_ack1++;
        end
        n_cmp++;
        if (n_ack1 != 4) begin
            n_bad++; $display("FAIL starve_rate: got %0d port1 grants expected 4", n_ack1);
        end
        settle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            mem[i] = 8'h80 + 8'(i); ref_mem[i] = 8'h80 + 8'(i);
        end
        for (int c = 0; c < 11; c++) begin
            drive_pt();
            bus.req0 = (c < 8); bus.addr0 = 16'(c);
            sample_pt();
            if (c < 8) begin
                n_cmp++;
                if (bus.ack0 !== 1'b1) begin
                    n_bad++; $display("FAIL b2b_ack: cycle %0d got %b expected 1", c, bus.ack0);
                end
            end
            if (c >= 2 && c < 10) begin
                n_cmp++;
                if ({bus.rvalid0, bus.rdata0} !== {1'b1, ref_mem[c-2]}) begin
                    n_bad++; $display("FAIL b2b_ret: cycle %0d got %h expected %h", c, {bus.rvalid0, bus.rdata0}, {1'b1, ref_mem[c-2]});
                end
            end
            if (c == 10) begin
                n_cmp++;
                if (bus.rvalid0 !== 1'b0) begin
                    n_bad++; $display("FAIL b2b_end: got %b expected 0", bus.rvalid0);
                end
            end
        end
        settle();
    endtask

    task automatic test_random();
        bit         p0 = 1'b0, p1 = 1'b0, w1 = 1'b0, g0, g1;
        logic [15:0] a0 = 16'h0, a1 = 16'h0;
        logic [7:0]  d1 = 8'h0;
        int          st = 0;
        bit          ev0 [4];
        bit          ev1 [4];
        logic [7:0]  ed0 [4];
        logic [7:0]  ed1 [4];
        for (int i = 0; i < 4; i++) begin
            ev0[i] = 1'b0; ev1[i] = 1'b0; ed0[i] = 8'h0; ed1[i] = 8'h0;
        end
        for (int c = 0; c < 320; c++) begin
            drive_pt();
            if (c < 300) begin
                if (!p0 && $urandom_range(0, 99) < 60) begin
                    p0 = 1'b1; a0 = 16'($urandom_range(0, 31));
                end
                if (!p1 && $urandom_range(0, 99) < 60) begin
                    p1 = 1'b1; w1 = 1'($urandom_range(0, 1));
                    a1 = 16'($urandom_range(0, 31)); d1 = 8'($urandom);
                end
            end
            bus.req0 = p0; bus.addr0 = a0;
            bus.req1 = p1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
            g1 = p1 && (!p0 || st == SL);
            g0 = p0 && !g1;
            st = (p1 && !g1) ? ((st < SL) ? st + 1 : st) : 0;
            if (g0) begin
                ev0[(c+2)%4] = 1'b1; ed0[(c+2)%4] = ref_mem[a0];
            end
            if (g1 && w1) ref_mem[a1] = d1;
            if (g1 && !w1) begin
                ev1[(c+2)%4] = 1'b1; ed1[(c+2)%4] = ref_mem[a1];
            end
            sample_pt();
            n_cmp++;
            if ({bus.ack0, bus.ack1} !== {g0, g1}) begin
                n_bad++; $display("FAIL rand_ack: cycle %0d got %b expected %b", c, {bus.ack0, bus.ack1}, {g0, g1});
            end
            n_cmp++;
            if ({bus.rvalid0, bus.rvalid1} !== {ev0[c%4], ev1[c%4]}) begin
                n_bad++; $display("FAIL rand_rvalid: cycle %0d got %b expected %b", c, {bus.rvalid0, bus.rvalid1}, {ev0[c%4], ev1[c%4]});
            end
            if (ev0[c%4]) begin
                n_cmp++;
                if (bus.rdata0 !== ed0[c%4]) begin
                    n_bad++; $display("FAIL rand_rdata0: cycle %0d got %h expected %h", c, bus.rdata0, ed0[c%4]);
                end
            end
            if (ev1[c%4]) begin
                n_cmp++;
                if (bus.rdata1 !== ed1[c%4]) begin
                    n_bad++; $display("FAIL rand_rdata1: cycle %0d got %h expected %h", c, bus.rdata1, ed1[c%4]);
                end
            end
            ev0[c%4] = 1'b0; ev1[c%4] = 1'b0;
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
        end
        settle();
    endtask

    task automatic test_clear();
        logic [7:0] exp_r0;
        drive_pt();
        bus.clear_start = 1'b1; bus.req0 = 1'b1; bus.addr0 = 16'h0002;
        exp_r0 = ref_mem[2];
        sample_pt();
        n_cmp++;
        if ({bus.ack0, bus.clear_busy, bus.sram_we} !== 3'b100) begin
            n_bad++; $display("FAIL clr_coincident: got %b expected 100", {bus.ack0, bus.clear_busy, bus.sram_we});
        end
        for (int k = 0; k < RS; k++) begin
            drive_pt();
            bus.clear_start = (k == 4);
            bus.req0 = 1'b0;
            bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0007;
            sample_pt();
            n_cmp++;
            if ({bus.clear_busy, bus.clear_done, bus.ack0, bus.ack1, bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata}
                !== {6'b100011, 16'(k), CV}) begin
                n_bad++; $display("FAIL clr_write: k %0d got %h expected %h", k,
                    {bus.clear_busy, bus.clear_done, bus.ack0, bus.ack1, bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata},
                    {6'b100011, 16'(k), CV});
            end
            if (k == 1) begin
                n_cmp++;
                if ({bus.rvalid0, bus.rdata0} !== {1'b1, exp_r0}) begin
                    n_bad++; $display("FAIL clr_inflight: got %h expected %h", {bus.rvalid0, bus.rdata0}, {1'b1, exp_r0});
                end
            end
        end
        drive_pt();
        bus.clear_start = 1'b0;
        sample_pt();
        n_cmp++;
        if ({bus.clear_busy, bus.clear_done, bus.ack1} !== 3'b011) begin
            n_bad++; $display("FAIL clr_done: got %b expected 011", {bus.clear_busy, bus.clear_done, bus.ack1});
        end
        for (int i = 0; i < RS; i++) ref_mem[i] = CV;
        drive_pt();
        bus.req1 = 1'b0;
        sample_pt();
        n_cmp++;
        if (bus.clear_done !== 1'b0) begin
            n_bad++; $display("FAIL clr_done_pulse: got %b expected 0", bus.clear_done);
        end
        drive_pt();
        sample_pt();
        n_cmp++;
        if ({bus.rvalid1, bus.rdata1} !== {1'b1, CV}) begin
            n_bad++; $display("FAIL clr_p1_read: got %h expected %h", {bus.rvalid1, bus.rdata1}, {1'b1, CV});
        end
        for (int c = 0; c < RS + 2; c++) begin
            drive_pt();
            bus.req0 = (c < RS); bus.addr0 = 16'(c);
            sample_pt();
            if (c >= 2) begin
                n_cmp++;
                if ({bus.rvalid0, bus.rdata0} !== {1'b1, ref_mem[c-2]}) begin
                    n_bad++; $display("FAIL clr_readback: cell %0d got %h expected %h", c - 2, {bus.rvalid0, bus.rdata0}, {1'b1, ref_mem[c-2]});
                end
            end
        end
        settle();
    endtask

    task automatic test_clear_abort();
        drive_pt();
        for (int i = 0; i < RS; i++) begin
            mem[i] = 8'h40 + 8'(i); ref_mem[i] = 8'h40 + 8'(i);
        end
        bus.clear_start = 1'b1;
        sample_pt();
        for (int k = 0; k < 5; k++) begin
            drive_pt();
            bus.clear_start = 1'b0;
            sample_pt();
        end
        drive_pt();
        n_cmp++;
        if (bus.sram_addr !== 16'h0005) begin
            n_bad++; $display("FAIL abort_addr: got %h expected 0005", bus.sram_addr);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.clear_busy, bus.sram_en, bus.sram_we} !== 3'b000) begin
            n_bad++; $display("FAIL abort_async: got %b expected 000", {bus.clear_busy, bus.sram_en, bus.sram_we});
        end
        drive_pt();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            sample_pt();
            n_cmp++;
            if ({bus.clear_busy, bus.clear_done} !== 2'b00) begin
                n_bad++; $display("FAIL abort_no_done: cycle %0d got %b expected 00", c, {bus.clear_busy, bus.clear_done});
            end
        end
        for (int i = 0; i < RS; i++) begin
            if (i != 5) begin
                n_cmp++;
                if (mem[i] !== ((i < 5) ? CV : ref_mem[i])) begin
                    n_bad++; $display("FAIL abort_cell: cell %0d got %h expected %h", i, mem[i], (i < 5) ? CV : ref_mem[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'($urandom); ref_mem[i] = mem[i];
        end
        mem[16'h0010] = 8'hA5; ref_mem[16'h0010] = 8'hA5;
        bus.addr0 = 16'h0; bus.addr1 = 16'h0; bus.wdata1 = 8'h0;
        idle_inputs();
        test_reset();
        test_port0_single();
        test_p1_write_read();
        test_starvation();
        test_back_to_back();
        test_random();
        test_clear();
        test_clear_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
